// File: rtl/match_event_counter_if.sv
// Match/alarm bus between the stimulus side (master) and the event counter (slave).
interface match_event_counter_if #(
  parameter int CNT_W = 8
);
  logic             in;
  logic             clr;
  logic             out;
  logic [CNT_W-1:0] count;
  logic             window_done;

  modport master (output in, clr, input out, count, window_done);
  modport slave  (input in, clr, output out, count, window_done);
endinterface

// File: rtl/match_event_counter.sv
// Counts match pulses per observation window and raises a registered alarm at THRESH hits.
// Define MATCH_ALARM_LATCH_EN to make the alarm sticky until clr/rst (HOLD then unused).
module match_event_counter #(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 16,
  parameter int THRESH = 3,
  parameter int HOLD   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  match_event_counter_if.slave bus
);
  localparam int TMR_W = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW - 1);
  localparam bit               INSTANT  = (THRESH == 1);

  typedef enum logic [1:0] {IDLE, COUNT, ALARM} state_t;

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] count_q, count_d, cnt_inc;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             out_q, out_d;
  logic             wd_q, wd_d;
  logic             thresh_hit, win_end, alarm_done;

  assign cnt_inc    = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
  assign thresh_hit = (cnt_inc >= THRESH_C);
  assign win_end    = (timer_q == TMR_LAST);

`ifdef MATCH_ALARM_LATCH_EN
  assign alarm_done = 1'b0;
`else
  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
  logic [HOLD_W-1:0] hold_q;

  // Hold counter restarts at 0 on the ALARM entry edge and runs only inside ALARM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    hold_q <= '0;
    else if (state_q == ALARM)  hold_q <= hold_q + 1'b1;
    else                        hold_q <= '0;
  end

  assign alarm_done = (hold_q == HOLD_LAST);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      timer_q <= '0;
      out_q   <= 1'b0;
      wd_q    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      count_q <= count_d;
      timer_q <= timer_d;
      out_q   <= out_d;
      wd_q    <= wd_d;
    end
  end

  // Threshold reached on the last window cycle wins over window expiry.
  always_comb begin
    state_nxt = state_q;
    if (bus.clr) begin
      state_nxt = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.in) state_nxt = INSTANT ? ALARM : COUNT;
        COUNT: begin
          if (bus.in && thresh_hit) state_nxt = ALARM;
          else if (win_end)         state_nxt = IDLE;
        end
        ALARM:   if (alarm_done) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    timer_d = timer_q;
    out_d   = 1'b0;
    wd_d    = 1'b0;
    case (state_nxt)
      IDLE: begin
        count_d = '0;
        timer_d = '0;
        wd_d    = (state_q == COUNT) && !bus.clr;
      end
      COUNT: begin
        if (state_q == COUNT) begin
          timer_d = timer_q + 1'b1;
          if (bus.in) count_d = cnt_inc;
        end else begin
          count_d = CNT_W'(1);
          timer_d = TMR_W'(1);
        end
      end
      ALARM: begin
        out_d   = 1'b1;
        count_d = THRESH_C;
        timer_d = '0;
      end
      default: ;
    endcase
  end

  assign bus.out         = out_q;
  assign bus.count       = count_q;
  assign bus.window_done = wd_q;
endmodule

// File: tb/tb_match_event_counter.sv
// Directed bench for match_event_counter with a time-based reference model checked every cycle.
module tb_match_event_counter;
  localparam int CNT_W  = 8;
  localparam int WINDOW = 16;
  localparam int THRESH = 3;
  localparam int HOLD   = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;
`ifdef MATCH_ALARM_LATCH_EN
  localparam int HOLD_M = 1 << 30;
`else
  localparam int HOLD_M = HOLD;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  match_event_counter_if #(.CNT_W(CNT_W)) bus ();

  match_event_counter #(
    .CNT_W(CNT_W), .WINDOW(WINDOW), .THRESH(THRESH), .HOLD(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: edge index, window start edge, hits in window, edge at which alarm ends.
  int c    = 0;
  int win  = -1;
  int hits = 0;
  int aend = -1;
  bit wd_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    wd_m = 1'b0;
    if (bus.clr) begin
      win = -1; hits = 0; aend = -1;
    end else if (c <= aend) begin
      if (c == aend) hits = 0;
    end else if (win < 0) begin
      if (bus.in) begin
        hits = 1;
        win  = c;
        if (hits >= THRESH) begin aend = c + HOLD_M; win = -1; end
      end
    end else begin
      if (bus.in && hits < CMAX) hits++;
      if (hits >= THRESH) begin
        aend = c + HOLD_M; win = -1;
      end else if (c - win == WINDOW - 1) begin
        wd_m = 1'b1; win = -1; hits = 0;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      win = -1; hits = 0; aend = -1; wd_m = 1'b0;
    end else begin
      c++;
      model_step();
      #1;
      chk("model_out",   32'(bus.out),         32'(c < aend));
      chk("model_count", 32'(bus.count),       32'(hits));
      chk("model_wdone", 32'(bus.window_done), 32'(wd_m));
    end
  end

  task automatic step(input logic i, input logic cl);
    bus.in  = i;
    bus.clr = cl;
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus.in  = 1'b0;
    bus.clr = 1'b0;
    #1;
    chk("reset_out",   32'(bus.out), 0);
    chk("reset_count", 32'(bus.count), 0);
    chk("reset_wdone", 32'(bus.window_done), 0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    repeat (3) step(1'b0, 1'b0);

`ifdef MATCH_ALARM_LATCH_EN
    for (int i = 0; i < 9; i++) begin
      step(i % 4 == 0, 1'b0);
      if (i == 8) begin
        chk("latch_enter_out", 32'(bus.out), 1);
        chk("latch_enter_cnt", 32'(bus.count), 3);
      end
    end
    for (int i = 0; i < 100; i++) begin
      step(i % 2 == 0, 1'b0);
      chk("latch_hold_out", 32'(bus.out), 1);
    end
    step(1'b1, 1'b1);
    chk("latch_clr_out", 32'(bus.out), 0);
    chk("latch_clr_cnt", 32'(bus.count), 0);
    repeat (3) step(1'b0, 1'b0);
`else
    // hits at 0,5,9: alarm from edge 9 for four cycles
    for (int i = 0; i < 16; i++) begin
      step(i == 0 || i == 5 || i == 9, 1'b0);
      if (i == 0) chk("w1_cnt1", 32'(bus.count), 1);
      if (i == 5) chk("w1_cnt2", 32'(bus.count), 2);
      if (i == 9) begin
        chk("w1_alarm_out", 32'(bus.out), 1);
        chk("w1_alarm_cnt", 32'(bus.count), 3);
      end
      if (i == 12) chk("w1_hold_last", 32'(bus.out), 1);
      if (i == 13) begin
        chk("w1_release_out", 32'(bus.out), 0);
        chk("w1_release_cnt", 32'(bus.count), 0);
      end
    end
    repeat (4) step(1'b0, 1'b0);

    // hits at 0 and 15: window expires below threshold
    for (int i = 0; i < 18; i++) begin
      step(i == 0 || i == 15, 1'b0);
      if (i == 14) chk("w2_cnt_before", 32'(bus.count), 1);
      if (i == 15) begin
        chk("w2_wdone", 32'(bus.window_done), 1);
        chk("w2_cnt_cleared", 32'(bus.count), 0);
        chk("w2_out", 32'(bus.out), 0);
      end
      if (i == 16) chk("w2_wdone_pulse", 32'(bus.window_done), 0);
    end
    repeat (2) step(1'b0, 1'b0);

    // third hit on final window cycle
    for (int i = 0; i < 21; i++) begin
      step(i == 0 || i == 1 || i == 15, 1'b0);
      if (i == 15) begin
        chk("w3_out", 32'(bus.out), 1);
        chk("w3_wdone", 32'(bus.window_done), 0);
        chk("w3_cnt", 32'(bus.count), 3);
      end
      if (i == 19) chk("w3_release", 32'(bus.out), 0);
    end

    // in held high through alarm: frozen count, exact release, exit-cycle hit ignored
    for (int i = 0; i < 9; i++) begin
      step(i <= 6, 1'b0);
      if (i == 5) begin
        chk("w4_hold_out", 32'(bus.out), 1);
        chk("w4_hold_cnt", 32'(bus.count), 3);
      end
      if (i == 6) begin
        chk("w4_exit_out", 32'(bus.out), 0);
        chk("w4_exit_cnt", 32'(bus.count), 0);
      end
      if (i == 7) chk("w4_no_retrig", 32'(bus.count), 0);
    end

    // clr overrides in
    step(1'b1, 1'b0);
    chk("clr_pre_cnt", 32'(bus.count), 1);
    step(1'b1, 1'b1);
    chk("clr_cnt", 32'(bus.count), 0);
    chk("clr_out", 32'(bus.out), 0);
    step(1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0);
    chk("clr_alarm_pre", 32'(bus.out), 1);
    step(1'b1, 1'b1);
    chk("clr_alarm_out", 32'(bus.out), 0);
    chk("clr_alarm_cnt", 32'(bus.count), 0);
    repeat (2) step(1'b0, 1'b0);

    // async reset mid-COUNT
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("rst_pre_cnt", 32'(bus.count), 2);
    #3 rst = 1'b1;
    #1;
    chk("rst_async_cnt", 32'(bus.count), 0);
    chk("rst_async_out", 32'(bus.out), 0);
    bus.in = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    step(1'b1, 1'b0);
    chk("rst_first_hit", 32'(bus.count), 1);
    repeat (WINDOW + 2) step(1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
